// File: rtl/conn_nibble_tx_pkg.sv
// Shared types and defaults for the nibble-wide connector transmitter.
package conn_nibble_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE
  } state_t;

  localparam int NIB_W       = 4;
  localparam int DEF_WORD_W  = 16;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous connector inputs.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/conn_nibble_tx.sv
// Sends words MSB nibble first over a four-phase strobe/ack connector,
// with a per-phase timeout and sticky error flag.
module conn_nibble_tx
  import conn_nibble_tx_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [NIB_W-1:0]  lnk_data,
  output logic              lnk_strb,
  output logic              lnk_first,
  input  logic              lnk_ack,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int NIBS = WORD_W / NIB_W;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int WCW  = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            nstate;
  logic [WORD_W-1:0] sh;
  logic [CW-1:0]     cnt;
  logic [WCW-1:0]    wcnt;
  logic              err_q;
  logic              ack_s;
  logic              ld;
  logic              adv;
  logic              tmo;
  logic              last;
  logic              act;

  sync2 u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lnk_ack),
    .q     (ack_s)
  );

  assign last = (cnt == CW'(NIBS - 1));
  assign tmo  = (state != IDLE) && (wcnt == WCW'(TIMEOUT));

  always_comb begin
    nstate = state;
    ld     = 1'b0;
    adv    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          ld     = 1'b1;
          nstate = SETUP;
        end
      end
      SETUP: begin
        if (!ack_s) nstate = STROBE;
      end
      STROBE: begin
        if (ack_s) nstate = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) begin
          if (last) begin
            nstate = IDLE;
          end else begin
            adv    = 1'b1;
            nstate = SETUP;
          end
        end
      end
      default: nstate = IDLE;
    endcase
    // a timeout overrides any handshake progress and drops the word
    if (tmo) begin
      nstate = IDLE;
      adv    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nstate;
      if (ld) begin
        sh  <= in_data;
        cnt <= '0;
      end else if (adv) begin
        sh  <= sh << NIB_W;
        cnt <= cnt + CW'(1);
      end
      if (nstate != state) begin
        wcnt <= '0;
      end else if (state != IDLE) begin
        wcnt <= wcnt + WCW'(1);
      end
      if (tmo) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign act       = (state != IDLE) && !reset;
  assign busy      = act;
  assign in_ready  = (state == IDLE) && !reset;
  assign lnk_data  = act ? sh[WORD_W-1 -: NIB_W] : '0;
  assign lnk_first = act && (cnt == '0);
  assign lnk_strb  = act && (state == STROBE) && !tmo;
  assign err       = err_q && !reset;

endmodule

// File: doc/conn_nibble_tx.md
CONN_NIBBLE_TX -- requirements
Module: conn_nibble_tx

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, the input word width; it must be a multiple of 4.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for each ack edge.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a word.
REQ-007 The block SHALL have port in_data, input, WORD_W bits: the word to send.
REQ-008 The block SHALL have port lnk_data, output, 4 bits: the nibble driven onto the connector.
REQ-009 The block SHALL have port lnk_strb, output, 1 bit: the nibble strobe onto the connector.
REQ-010 The block SHALL have port lnk_first, output, 1 bit: marks the first nibble of a word.
REQ-011 The block SHALL have port lnk_ack, input, 1 bit: the acknowledge returned through the connector from the far board.
REQ-012 The block SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-013 The block SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-014 The block SHALL have port err_clr, input, 1 bit: clears err.

Function
REQ-015 lnk_ack SHALL pass through a 2-flop synchronizer; all uses below refer to the synchronized value ack_s, which lags lnk_ack by 2 cycles.
REQ-016 The FSM SHALL have the states IDLE, SETUP, STROBE and RELEASE.
REQ-017 In IDLE, in_ready SHALL be 1; an in_valid&in_ready cycle SHALL load in_data into the shift register, clear the nibble count, and move to SETUP.
REQ-018 In SETUP, lnk_data SHALL equal the shift register MSB nibble, lnk_first SHALL equal (count==0), and lnk_strb SHALL be 0.
REQ-019 SETUP SHALL move to STROBE only if ack_s==0, otherwise it stays; this guarantees at least 1 cycle of data setup before the strobe.
REQ-020 In STROBE, lnk_strb SHALL be 1, and lnk_data and lnk_first SHALL be held stable; the FSM moves to RELEASE when ack_s==1.
REQ-021 In RELEASE, lnk_strb SHALL be 0 and data SHALL be held; when ack_s==0, then:
- if count==WORD_W/4-1, the FSM goes to IDLE;
- otherwise count increments, the shift register shifts left 4, and the FSM goes to SETUP.
REQ-022 Nibble order SHALL be MSB first; a word SHALL take WORD_W/4 full four-phase handshakes.
REQ-023 busy SHALL be 1 in every state except IDLE; in_ready SHALL be 0 whenever busy is 1.
REQ-024 A wait counter SHALL clear on every state entry and increment each cycle spent in SETUP, STROBE or RELEASE.
REQ-025 When the wait counter reaches TIMEOUT, the block SHALL:
- set err;
- drive lnk_strb to 0;
- drop the word;
- return to IDLE.
REQ-026 err SHALL be sticky until err_clr=1; if a timeout and err_clr occur in the same cycle, set wins.
REQ-027 A new word SHALL NOT be accepted in the cycle the FSM returns to IDLE; the earliest acceptance is the following cycle.
REQ-028 Activity on in_valid while busy SHALL have no effect; in_data is not sampled.

Reset
REQ-029 While reset=1, the state SHALL be IDLE and the following outputs SHALL be 0: in_ready, lnk_data, lnk_strb, lnk_first, busy, err.
REQ-030 While reset=1, the synchronizer, shift register, nibble count and wait counter SHALL be 0.
REQ-031 Reset asserted mid-word SHALL abort the word immediately with no partial completion; lnk_strb is 0 on the next edge.
REQ-032 in_ready SHALL become 1 on the first cycle after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration, the nibble width constant (4), and the default WORD_W and TIMEOUT values.
REQ-034 The 2-flop synchronizer SHALL be a separate sub-module, sync2, reused for other connector inputs.
REQ-035 All other logic SHALL be flat in conn_nibble_tx.

Verification
REQ-036 The bench SHALL cover a basic word: in_data=16'hA5C3 with a far-end model acking after 3 cycles -> lnk_data sequence A,5,C,3, lnk_first=1 only on A, in_ready back to 1 after the 4th handshake.
REQ-037 The bench SHALL cover back-to-back words: 16'h1234 then 16'hFEDC, with in_valid held high -> nibbles 1,2,3,4,F,E,D,C, and a gap of at least 1 IDLE cycle between the two words.
REQ-038 The bench SHALL cover a timeout: TIMEOUT=10 and ack held low -> err=1 and lnk_strb=0 eleven cycles or fewer after strobe rise, and busy=0.
REQ-039 The bench SHALL cover a stuck ack: ack held high at word start -> FSM stays in SETUP with lnk_strb=0 until ack falls, or errors at TIMEOUT.
REQ-040 The bench SHALL cover reset mid-transfer: reset asserted during STROBE of the 2nd nibble -> all outputs 0 next cycle, and a fresh word 16'h0F0F then sends 0,F,0,F correctly.
REQ-041 The bench SHALL cover err clearing: err_clr pulsed while err=1 -> err=0 next cycle; err_clr coincident with a new timeout -> err stays 1.
